// File: rtl/sub_33_serial.sv
// sub_33_serial: multi-cycle subtractor computing a - b - bin one DIGIT-bit
// slice per clock. Subtraction is done as a + ~b + ~bin. The operands are
// zero-padded up to a whole number of slices. Because the padding is zero in
// both a and ~b, the carry out of bit WIDTH-1 lands in pad bit WIDTH and does
// not propagate any further.
module sub_33_serial #(
  parameter int WIDTH = 33,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             overflow
);

  localparam int NSL = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int PW  = NSL * DIGIT;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST_K = CW'(NSL - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;

  logic [PW-1:0]   a_r;
  logic [PW-1:0]   nb_r;
  logic [PW-1:0]   res_r;
  logic            carry_r;
  logic [CW-1:0]   cnt_r;
  logic            a_msb_r;
  logic            b_msb_r;

  logic [WIDTH-1:0] nb_in_s;
  logic             accept_s;
  logic             last_s;
  logic [DIGIT:0]   slice_s;
  logic [PW+DIGIT:0] ext_s;
  logic [PW:0]      full_s;
  logic [WIDTH-1:0] diff_fin_s;
  logic             final_c_s;

  // One slice of the ripple: x + y + carry-in, with the carry-out in the top bit.
  function automatic logic [DIGIT:0] slice_add(input logic [DIGIT-1:0] x,
                                               input logic [DIGIT-1:0] y,
                                               input logic             ci);
    slice_add = {1'b0, x} + {1'b0, y} + {{DIGIT{1'b0}}, ci};
  endfunction

  // State register; reset overrides any in-flight operation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode: IDLE -> RUN on start, RUN for NSL slices, one DONE cycle.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = (state_r == IDLE) && start;
    last_s      = (state_r == RUN) && (cnt_r == LAST_K);
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE:    state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Slice adder and the view of the full result once the current slice is
  // shifted in from the top. This view is complete on the last slice.
  always_comb begin
    nb_in_s    = ~b;
    slice_s    = slice_add(a_r[DIGIT-1:0], nb_r[DIGIT-1:0], carry_r);
    ext_s      = {slice_s, res_r};
    full_s     = ext_s[PW+DIGIT:DIGIT];
    diff_fin_s = full_s[WIDTH-1:0];
    final_c_s  = full_s[WIDTH];
  end

  // Datapath: capture the operands, step one slice per RUN cycle, and publish
  // the results only when entering DONE.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r      <= {PW{1'b0}};
      nb_r     <= {PW{1'b0}};
      res_r    <= {PW{1'b0}};
      carry_r  <= 1'b0;
      cnt_r    <= {CW{1'b0}};
      a_msb_r  <= 1'b0;
      b_msb_r  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      diff     <= {WIDTH{1'b0}};
      bout     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (accept_s) begin
            a_r     <= PW'(a);
            nb_r    <= PW'(nb_in_s);
            res_r   <= {PW{1'b0}};
            carry_r <= ~bin;
            cnt_r   <= {CW{1'b0}};
            a_msb_r <= a[WIDTH-1];
            b_msb_r <= b[WIDTH-1];
            busy    <= 1'b1;
          end else begin
            busy    <= 1'b0;
          end
        end
        RUN: begin
          a_r     <= a_r >> DIGIT;
          nb_r    <= nb_r >> DIGIT;
          res_r   <= full_s[PW-1:0];
          carry_r <= slice_s[DIGIT];
          cnt_r   <= cnt_r + CW'(1);
          busy    <= 1'b1;
          if (last_s) begin
            diff     <= diff_fin_s;
            bout     <= ~final_c_s;
            overflow <= (a_msb_r != b_msb_r) && (diff_fin_s[WIDTH-1] != a_msb_r);
            done     <= 1'b1;
          end else begin
            done     <= 1'b0;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sub_33_serial.sv
// Scoreboard bench for sub_33_serial. The stimulus process pushes the expected
// results and the start cycle of each operation. A monitor pops them on every
// done pulse and checks the result values and the latency. Four instances are
// built, with DIGIT = 4, 1, 5 and 33.
module tb_sub_33_serial;

  typedef struct {
    logic [32:0] d;
    logic        bo;
    logic        ov;
    int          t;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        start0;
  logic        startx;
  logic [32:0] a;
  logic [32:0] b;
  logic        bin;

  logic [3:0]  busy_v;
  logic [3:0]  done_v;
  logic [3:0]  bout_v;
  logic [3:0]  ovf_v;
  logic [32:0] diff_v [4];

  exp_t        sbq [4][$];
  int          lat [4] = '{10, 34, 8, 2};
  int          cyc;
  int          errors;
  int          checks;
  exp_t        mon_e;

  sub_33_serial #(.WIDTH(33), .DIGIT(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .a(a), .b(b), .bin(bin),
    .busy(busy_v[0]), .done(done_v[0]), .diff(diff_v[0]), .bout(bout_v[0]), .overflow(ovf_v[0]));
  sub_33_serial #(.WIDTH(33), .DIGIT(1)) dut1 (
    .clk(clk), .reset(reset), .start(startx), .a(a), .b(b), .bin(bin),
    .busy(busy_v[1]), .done(done_v[1]), .diff(diff_v[1]), .bout(bout_v[1]), .overflow(ovf_v[1]));
  sub_33_serial #(.WIDTH(33), .DIGIT(5)) dut2 (
    .clk(clk), .reset(reset), .start(startx), .a(a), .b(b), .bin(bin),
    .busy(busy_v[2]), .done(done_v[2]), .diff(diff_v[2]), .bout(bout_v[2]), .overflow(ovf_v[2]));
  sub_33_serial #(.WIDTH(33), .DIGIT(33)) dut3 (
    .clk(clk), .reset(reset), .start(startx), .a(a), .b(b), .bin(bin),
    .busy(busy_v[3]), .done(done_v[3]), .diff(diff_v[3]), .bout(bout_v[3]), .overflow(ovf_v[3]));

  // Free-running clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Edge counter, used to measure latency.
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endfunction

  // Monitor: every done pulse must match the oldest expected entry of its instance.
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (done_v[i] === 1'b1) begin
        if (sbq[i].size() == 0) begin
          checks++;
          errors++;
          $display("FAIL spurious_done dut%0d: got done=1 required done=0", i);
        end else begin
          mon_e = sbq[i].pop_front();
          chk($sformatf("diff dut%0d", i), 64'(diff_v[i]), 64'(mon_e.d));
          chk($sformatf("bout dut%0d", i), 64'(bout_v[i]), 64'(mon_e.bo));
          chk($sformatf("overflow dut%0d", i), 64'(ovf_v[i]), 64'(mon_e.ov));
          chk($sformatf("latency dut%0d", i), 64'(cyc - mon_e.t), 64'(lat[i]));
        end
      end
    end
  end

  // Called at a negedge. Drives one start on dut0 (lo == 0) or on the three
  // DIGIT variants (lo == 1), and optionally pushes the expected result.
  task automatic issue(input int lo, input int hi, input logic [32:0] ia, input logic [32:0] ib,
                       input logic ibin, input logic [32:0] ed, input logic ebo, input logic eov,
                       input bit push);
    exp_t e;
    a   = ia;
    b   = ib;
    bin = ibin;
    if (lo == 0) start0 = 1'b1;
    else         startx = 1'b1;
    e.d  = ed;
    e.bo = ebo;
    e.ov = eov;
    e.t  = cyc;
    if (push) begin
      for (int i = lo; i <= hi; i++) sbq[i].push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    start0 = 1'b0;
    startx = 1'b0;
    for (int i = lo; i <= hi; i++) chk($sformatf("busy_rise dut%0d", i), 64'(busy_v[i]), 64'd1);
  endtask

  // Waits, with a bounded budget, until the scoreboard is drained and the
  // instances are idle again.
  task automatic wait_idle(input int lo, input int hi);
    int  n;
    bit  pend;
    n = 0;
    pend = 1'b1;
    while (pend && n < 200) begin
      pend = 1'b0;
      for (int i = lo; i <= hi; i++) if (sbq[i].size() != 0 || busy_v[i] !== 1'b0) pend = 1'b1;
      if (pend) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (pend) begin
      errors++;
      $display("FAIL timeout dut%0d..%0d: got %0d cycles required fewer than 200", lo, hi, n);
    end
    repeat (2) @(negedge clk);
  endtask

  // Directed stimulus sequence.
  initial begin
    cyc    = 0;
    errors = 0;
    checks = 0;
    reset  = 1'b1;
    start0 = 1'b0;
    startx = 1'b0;
    a      = 33'd0;
    b      = 33'd0;
    bin    = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("reset busy dut%0d", i), 64'(busy_v[i]), 64'd0);
      chk($sformatf("reset done dut%0d", i), 64'(done_v[i]), 64'd0);
      chk($sformatf("reset diff dut%0d", i), 64'(diff_v[i]), 64'd0);
      chk($sformatf("reset bout dut%0d", i), 64'(bout_v[i]), 64'd0);
      chk($sformatf("reset ovf dut%0d", i), 64'(ovf_v[i]), 64'd0);
    end

    // Basic subtraction vectors on the default DIGIT=4 instance.
    issue(0, 0, 33'd5, 33'd3, 1'b0, 33'd2, 1'b0, 1'b0, 1'b1);
    wait_idle(0, 0);
    issue(0, 0, 33'd0, 33'd1, 1'b0, 33'h1_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    wait_idle(0, 0);
    issue(0, 0, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0, 33'h1_0000_0000, 1'b1, 1'b1, 1'b1);
    wait_idle(0, 0);
    issue(0, 0, 33'h1_2345_6789, 33'h1_2345_6789, 1'b1, 33'h1_FFFF_FFFF, 1'b1, 1'b0, 1'b1);
    wait_idle(0, 0);
    issue(0, 0, 33'h1_0000_0000, 33'd1, 1'b0, 33'h0_FFFF_FFFF, 1'b0, 1'b1, 1'b1);
    wait_idle(0, 0);

    // A start during RUN must be ignored, leaving the latched operands intact.
    issue(0, 0, 33'd10, 33'd4, 1'b0, 33'd6, 1'b0, 1'b0, 1'b1);
    repeat (2) @(negedge clk);
    a      = 33'd0;
    b      = 33'd0;
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_idle(0, 0);
    repeat (12) @(negedge clk);

    // Reset in the middle of RUN abandons the operation.
    issue(0, 0, 33'd7, 33'd2, 1'b1, 33'd0, 1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset busy", 64'(busy_v[0]), 64'd0);
    chk("midreset done", 64'(done_v[0]), 64'd0);
    chk("midreset diff", 64'(diff_v[0]), 64'd0);
    chk("midreset bout", 64'(bout_v[0]), 64'd0);
    chk("midreset ovf", 64'(ovf_v[0]), 64'd0);
    repeat (15) @(negedge clk);
    issue(0, 0, 33'd7, 33'd2, 1'b1, 33'd4, 1'b0, 1'b0, 1'b1);
    wait_idle(0, 0);

    // DIGIT = 1, 5 and 33 variants with the first and third vectors.
    issue(1, 3, 33'd5, 33'd3, 1'b0, 33'd2, 1'b0, 1'b0, 1'b1);
    wait_idle(1, 3);
    issue(1, 3, 33'h0_FFFF_FFFF, 33'h1_FFFF_FFFF, 1'b0, 33'h1_0000_0000, 1'b1, 1'b1, 1'b1);
    wait_idle(1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run can never hang.
  initial begin
    #500000;
    $display("FAIL watchdog: got no completion required finish before 500000");
    $fatal(1);
  end

endmodule
